// File: rtl/mmu_seq_pkg.sv
// rtl/mmu_seq_pkg.sv - shared defaults and FSM state encoding for the MMU tile sequencer
// Purpose: one place for the sequencer's default sizing and its 3-bit state encoding.
// Contents:
//   DEF_TILE_NUM_MAX  default largest legal tile count per job
//   DEF_TIMEOUT       default WAIT-cycle budget for a done pulse
//   seq_state_e       IDLE, ISSUE, WAIT, FINISH, ERROR
package mmu_seq_pkg;

  localparam int DEF_TILE_NUM_MAX = 16;
  localparam int DEF_TIMEOUT      = 64;

  localparam logic [2:0] ENC_IDLE   = 3'd0;
  localparam logic [2:0] ENC_ISSUE  = 3'd1;
  localparam logic [2:0] ENC_WAIT   = 3'd2;
  localparam logic [2:0] ENC_FINISH = 3'd3;
  localparam logic [2:0] ENC_ERROR  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = ENC_IDLE,
    ST_ISSUE  = ENC_ISSUE,
    ST_WAIT   = ENC_WAIT,
    ST_FINISH = ENC_FINISH,
    ST_ERROR  = ENC_ERROR
  } seq_state_e;

endpackage

// File: rtl/mmu_tile_sequencer_if.sv
// rtl/mmu_tile_sequencer_if.sv - job and engine handshake bundle of the MMU tile sequencer
// Purpose: groups the controller-side job handshake and the engine-side start/done pulses.
// Signals:
//   job_valid_i, job_tiles_i[TW]   job request from the controller
//   job_ready_o                    sequencer can take a job
//   start_o, done_i                one-cycle pulses to/from the compute engine
//   tile_idx_o[IW]                 index of the tile in flight
//   busy_o, job_done_o, err_o      status back to the controller
// Modports: master = sequencer side, slave = controller/engine side.
interface mmu_tile_sequencer_if
  import mmu_seq_pkg::*;
#(
  parameter int TW = $clog2(DEF_TILE_NUM_MAX) + 1,
  parameter int IW = $clog2(DEF_TILE_NUM_MAX)
);

  logic          job_valid_i;
  logic          job_ready_o;
  logic [TW-1:0] job_tiles_i;
  logic          start_o;
  logic          done_i;
  logic [IW-1:0] tile_idx_o;
  logic          busy_o;
  logic          job_done_o;
  logic          err_o;

  modport master (
    input  job_valid_i, job_tiles_i, done_i,
    output job_ready_o, start_o, tile_idx_o, busy_o, job_done_o, err_o
  );

  modport slave (
    output job_valid_i, job_tiles_i, done_i,
    input  job_ready_o, start_o, tile_idx_o, busy_o, job_done_o, err_o
  );

endinterface

// File: rtl/mmu_wait_timer.sv
// rtl/mmu_wait_timer.sv - clear/enable WAIT-cycle counter with expiry flag
// Purpose: counts cycles spent waiting for the engine's done pulse.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   clear      synchronous clear (takes priority over enable)
//   enable     count up by one
//   expired    high while the count sits at TIMEOUT-1
module mmu_wait_timer
  import mmu_seq_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Wrapping past LIMIT is harmless: the sequencer leaves WAIT on the
  // expired cycle and clears the counter before it waits again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/mmu_tile_sequencer.sv
// rtl/mmu_tile_sequencer.sv - issues one start pulse per tile and waits for each done pulse
// Purpose: accepts an N-tile job, pulses start_o per tile, waits for done_i with a
// watchdog, and reports completion or failure back to the controller.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   bus        mmu_tile_sequencer_if.master (job handshake, start/done, status)
module mmu_tile_sequencer
  import mmu_seq_pkg::*;
#(
  parameter int TILE_NUM_MAX = DEF_TILE_NUM_MAX,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input logic                  clk,
  input logic                  rst,
  mmu_tile_sequencer_if.master bus
);

  localparam int TW = $clog2(TILE_NUM_MAX) + 1;
  localparam int IW = $clog2(TILE_NUM_MAX);
  localparam logic [TW-1:0] MAX_TILES = TW'(TILE_NUM_MAX);

  seq_state_e    state;
  seq_state_e    state_nxt;
  logic [TW-1:0] tile_cnt;
  logic [IW-1:0] tile_idx;
  logic          err_q;
  logic          ready_q;
  logic          start_q;
  logic          busy_q;
  logic          job_done_q;
  logic          accept;
  logic          last_tile;
  logic          timer_expired;
  logic          timer_clear;
  logic          timer_enable;

  assign accept    = (state == ST_IDLE) && bus.job_valid_i;
  // Only evaluated in WAIT, where the latched count is at least 1.
  assign last_tile = ({1'b0, tile_idx} == (tile_cnt - TW'(1)));

  // Timer runs only in WAIT and restarts from zero on every fresh wait.
  assign timer_clear  = (state != ST_WAIT);
  assign timer_enable = (state == ST_WAIT);

  mmu_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.job_valid_i) begin
          if (bus.job_tiles_i == '0) begin
            state_nxt = ST_FINISH;
          end else if (bus.job_tiles_i > MAX_TILES) begin
            state_nxt = ST_ERROR;
          end else begin
            state_nxt = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        // done_i wins over a simultaneous timer expiry.
        if (bus.done_i) begin
          state_nxt = last_tile ? ST_FINISH : ST_ISSUE;
        end else if (timer_expired) begin
          state_nxt = ST_ERROR;
        end
      end
      ST_FINISH: state_nxt = ST_IDLE;
      ST_ERROR:  state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one is a clean
  // flop that matches the state it decodes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      tile_cnt   <= '0;
      tile_idx   <= '0;
      err_q      <= 1'b0;
      ready_q    <= 1'b1;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      job_done_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      ready_q    <= (state_nxt == ST_IDLE);
      start_q    <= (state_nxt == ST_ISSUE);
      busy_q     <= (state_nxt != ST_IDLE);
      job_done_q <= (state_nxt == ST_FINISH) || (state_nxt == ST_ERROR);

      if (accept) begin
        tile_cnt <= bus.job_tiles_i;
        tile_idx <= '0;
      end else if ((state == ST_WAIT) && bus.done_i && !last_tile) begin
        tile_idx <= tile_idx + IW'(1);
      end

      // An illegal count is accepted and errors in the same edge, so the
      // set must override the clear-on-accept.
      if (state_nxt == ST_ERROR) begin
        err_q <= 1'b1;
      end else if (accept) begin
        err_q <= 1'b0;
      end
    end
  end

  assign bus.job_ready_o = ready_q;
  assign bus.start_o     = start_q;
  assign bus.tile_idx_o  = tile_idx;
  assign bus.busy_o      = busy_q;
  assign bus.job_done_o  = job_done_q;
  assign bus.err_o       = err_q;

endmodule

// File: tb/tb_mmu_tile_sequencer.sv
// tb/tb_mmu_tile_sequencer.sv - self-checking bench for mmu_tile_sequencer
module tb_mmu_tile_sequencer;

  localparam int TILE_NUM_MAX = 16;
  localparam int TIMEOUT      = 64;
  localparam int TW           = $clog2(TILE_NUM_MAX) + 1;
  localparam int IW           = $clog2(TILE_NUM_MAX);
  localparam int JOB_BOUND    = 4000;

  logic clk;
  logic rst;

  mmu_tile_sequencer_if #(.TW(TW), .IW(IW)) sif ();

  mmu_tile_sequencer #(
    .TILE_NUM_MAX (TILE_NUM_MAX),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s/job_ready", tag), int'(sif.job_ready_o), 1);
    check($sformatf("%s/busy", tag), int'(sif.busy_o), 0);
    check($sformatf("%s/start", tag), int'(sif.start_o), 0);
    check($sformatf("%s/job_done", tag), int'(sif.job_done_o), 0);
    check($sformatf("%s/err", tag), int'(sif.err_o), 0);
    check($sformatf("%s/tile_idx", tag), int'(sif.tile_idx_o), 0);
  endtask

  // Per-tile engine latency: done_i comes lat_q[i] cycles after start of tile i;
  // a latency above TIMEOUT means the engine never answers that tile.
  int lat_q[$];

  // Reference model: cycle numbers relative to the job's handshake cycle (0).
  int m_starts[$];
  int m_jd;
  bit m_err;
  bit prev_err;

  task automatic model_job(input int n);
    int s;
    bit stop;
    m_starts.delete();
    m_err = 1'b0;
    stop  = 1'b0;
    if (n == 0) begin
      m_jd = 1;
    end else if (n > TILE_NUM_MAX) begin
      m_jd  = 1;
      m_err = 1'b1;
    end else begin
      s = 1;
      for (int i = 0; i < n; i++) begin
        if (!stop) begin
          m_starts.push_back(s);
          if (lat_q[i] > TIMEOUT) begin
            m_jd  = s + TIMEOUT + 1;
            m_err = 1'b1;
            stop  = 1'b1;
          end else begin
            s = s + lat_q[i] + 1;
          end
        end
      end
      if (!m_err) m_jd = s;
    end
  endtask

  // Observations of one job.
  int o_starts[$];
  int o_jd;
  bit o_err;
  bit o_err0;
  bit o_err1;
  bit o_ready0;
  bit o_idx_ok;
  bit o_busy_ok;
  bit o_seen;

  // Entered and left #1 after a rising edge with the DUT idle. Drives the
  // handshake in cycle 0, plays the engine, and injects ignored done_i
  // pulses in the handshake cycle and in each predicted ISSUE cycle.
  task automatic run_job(input int n);
    int pending;
    int issue_pred;
    int k;
    o_starts.delete();
    o_jd      = -1;
    o_err     = 1'b0;
    o_idx_ok  = 1'b1;
    o_busy_ok = 1'b1;
    o_seen    = 1'b0;
    pending   = -1;
    issue_pred = 1;
    k         = 0;
    sif.job_valid_i = 1'b1;
    sif.job_tiles_i = TW'(n);
    for (int c = 0; c < JOB_BOUND && !o_seen; c++) begin
      sif.done_i = (c == pending) || (c == 0) || (c == issue_pred);
      @(negedge clk);
      if (c == 0) begin
        o_ready0 = sif.job_ready_o;
        o_err0   = sif.err_o;
      end
      if (c == 1) o_err1 = sif.err_o;
      if (c >= 1 && !sif.busy_o) o_busy_ok = 1'b0;
      if (sif.start_o) begin
        if (int'(sif.tile_idx_o) != k) o_idx_ok = 1'b0;
        o_starts.push_back(c);
        pending = -1;
        if (k < lat_q.size()) begin
          if (lat_q[k] <= TIMEOUT) begin
            pending    = c + lat_q[k];
            issue_pred = pending + 1;
          end
        end
        k++;
      end
      if (sif.job_done_o) begin
        o_jd   = c;
        o_err  = sif.err_o;
        o_seen = 1'b1;
      end
      @(posedge clk);
      #1;
      sif.job_valid_i = 1'b0;
    end
    sif.done_i = 1'b0;
  endtask

  task automatic do_job(input int n, input string tag);
    model_job(n);
    run_job(n);
    check($sformatf("%s/job_done_seen", tag), int'(o_seen), 1);
    check($sformatf("%s/ready_at_handshake", tag), int'(o_ready0), 1);
    check($sformatf("%s/err_before_accept", tag), int'(o_err0), int'(prev_err));
    check($sformatf("%s/err_after_accept", tag), int'(o_err1), (n > TILE_NUM_MAX) ? 1 : 0);
    check($sformatf("%s/n_starts", tag), o_starts.size(), m_starts.size());
    for (int i = 0; i < o_starts.size() && i < m_starts.size(); i++)
      check($sformatf("%s/start_cycle[%0d]", tag, i), o_starts[i], m_starts[i]);
    check($sformatf("%s/job_done_cycle", tag), o_jd, m_jd);
    check($sformatf("%s/err", tag), int'(o_err), int'(m_err));
    check($sformatf("%s/tile_idx_seq", tag), int'(o_idx_ok), 1);
    check($sformatf("%s/busy_during_job", tag), int'(o_busy_ok), 1);
    prev_err = m_err;
  endtask

  typedef struct {
    int tiles;
    int lat;
    int exp_starts;
    int exp_jd;
    bit exp_err;
  } vec_t;

  vec_t vecs[9];

  int  n;
  bit  flag_ok;

  initial begin
    vecs[0] = '{3,  5,   3,  19, 1'b0};  // 5-cycle engine, 3 tiles
    vecs[1] = '{0,  1,   0,   1, 1'b0};  // empty job
    vecs[2] = '{17, 1,   0,   1, 1'b1};  // one above the legal max
    vecs[3] = '{1,  100, 1,  66, 1'b1};  // engine never answers
    vecs[4] = '{1,  64,  1,  66, 1'b0};  // done on the timeout-limit cycle
    vecs[5] = '{16, 1,   16, 33, 1'b0};  // max tiles, fastest engine
    vecs[6] = '{2,  63,  2, 129, 1'b0};  // one cycle inside the limit
    vecs[7] = '{31, 1,   0,   1, 1'b1};  // largest encodable count
    vecs[8] = '{2,  65,  1,  66, 1'b1};  // first tile times out

    rst             = 1'b0;
    sif.job_valid_i = 1'b0;
    sif.job_tiles_i = '0;
    sif.done_i      = 1'b0;
    prev_err        = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("por");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int v = 0; v < 9; v++) begin
      lat_q.delete();
      for (int i = 0; i < vecs[v].tiles && i < TILE_NUM_MAX; i++) lat_q.push_back(vecs[v].lat);
      do_job(vecs[v].tiles, $sformatf("vec%0d", v));
      check($sformatf("vec%0d/tbl_starts", v), o_starts.size(), vecs[v].exp_starts);
      check($sformatf("vec%0d/tbl_job_done", v), o_jd, vecs[v].exp_jd);
      check($sformatf("vec%0d/tbl_err", v), int'(o_err), int'(vecs[v].exp_err));
    end

    // err_o holds through idle cycles after an illegal job, then clears on the next accept.
    lat_q.delete();
    do_job(17, "sticky_bad");
    flag_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (!sif.err_o || !sif.job_ready_o) flag_ok = 1'b0;
      @(posedge clk);
      #1;
    end
    check("sticky/err_held_idle", int'(flag_ok), 1);
    lat_q.delete();
    lat_q.push_back(2);
    do_job(1, "sticky_good");

    // Reset during WAIT of tile 1, then a stray done_i two cycles later.
    sif.job_valid_i = 1'b1;
    sif.job_tiles_i = TW'(3);
    sif.done_i      = 1'b0;
    @(posedge clk);
    #1;
    sif.job_valid_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    sif.done_i = 1'b1;
    @(posedge clk);
    #1;
    sif.done_i = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_mid/tile_idx_before", int'(sif.tile_idx_o), 1);
    check("rst_mid/busy_before", int'(sif.busy_o), 1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid_async");
    @(posedge clk);
    #1;
    check_reset_outputs("rst_mid_held");
    rst = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    sif.done_i = 1'b1;
    @(posedge clk);
    #1;
    sif.done_i = 1'b0;
    flag_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (sif.start_o || !sif.job_ready_o || sif.busy_o || sif.job_done_o) flag_ok = 1'b0;
      @(posedge clk);
      #1;
    end
    check("rst_mid/stray_done_ignored", int'(flag_ok), 1);
    prev_err = 1'b0;

    // Randomized jobs against the reference model.
    for (int j = 0; j < 25; j++) begin
      if ($urandom_range(0, 7) == 0) n = int'($urandom_range(0, 20));
      else n = int'($urandom_range(1, 8));
      lat_q.delete();
      for (int i = 0; i < TILE_NUM_MAX; i++) begin
        if ($urandom_range(0, 1) == 1) lat_q.push_back(int'($urandom_range(1, 6)));
        else lat_q.push_back(int'($urandom_range(1, TIMEOUT + 4)));
      end
      do_job(n, $sformatf("rand%0d", j));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected summary");
    $fatal(1, "watchdog");
  end

endmodule
